// File: rtl/mode_sequencer.sv
// ---------------------------------------------------------------------------
// mode_sequencer
//
// Small multi-mode sequencer built around a data register y, a step counter
// s and a sticky overflow flag b. An idle controller samples a 2-bit mode
// request and runs one of three modes to completion before accepting the
// next request:
//   load      : y <= x, then s <= y[SW-1:0]
//   count     : s counts down while start is high; y increments each time
//               s underflows, and b latches a y wrap-around
//   enumerate : after start falls, emit ENUM_START, ENUM_START-ENUM_STEP, ...
//               each value held HOLD cycles, while active is high
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous active-high reset
//   x       in   W   load data
//   on      in   2   mode request (0 none, 1 enumerate, 2 count, 3 load)
//   start   in   1   mode qualifier, level-sensitive
//   y       out  W   data register
//   s       out  SW  step counter
//   b       out  1   sticky overflow flag (cleared on each mode entry)
//   regime  out  2   current mode code, 0 when idle
//   active  out  1   high while enumerate is emitting values
//   busy    out  1   combinational, high whenever not idle
//   done    out  1   one-cycle pulse on return to idle
// ---------------------------------------------------------------------------
module mode_sequencer #(
    parameter int W          = 8,
    parameter int SW         = 3,
    parameter int ENUM_START = 6,
    parameter int ENUM_STEP  = 2,
    parameter int HOLD       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x,
    input  logic [1:0]    on,
    input  logic          start,
    output logic [W-1:0]  y,
    output logic [SW-1:0] s,
    output logic          b,
    output logic [1:0]    regime,
    output logic          active,
    output logic          busy,
    output logic          done
);

    // Hold counter only ever holds HOLD-1 down to 0.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);
    localparam logic [SW-1:0] START_V = SW'(ENUM_START);
    localparam logic [SW-1:0] STEP_V  = SW'(ENUM_STEP);

    localparam logic [1:0] RG_IDLE  = 2'd0;
    localparam logic [1:0] RG_ENUM  = 2'd1;
    localparam logic [1:0] RG_COUNT = 2'd2;
    localparam logic [1:0] RG_LOAD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        COUNT,
        ENUM_WAIT,
        ENUM_RUN
    } state_t;

    state_t        state;
    logic [HW-1:0] hold;
    logic          can_step;

    // Compared at 32 bits so an ENUM_STEP wider than s simply never steps.
    assign can_step = (int'(s) >= ENUM_STEP);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y      <= '0;
            s      <= '0;
            b      <= 1'b0;
            regime <= RG_IDLE;
            active <= 1'b0;
            done   <= 1'b0;
            hold   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Mode request is only looked at here; every entry
                    // clears the sticky overflow flag.
                    case (on)
                        2'd3: begin
                            state  <= LOAD0;
                            regime <= RG_LOAD;
                            b      <= 1'b0;
                        end
                        2'd2: begin
                            state  <= COUNT;
                            regime <= RG_COUNT;
                            b      <= 1'b0;
                        end
                        2'd1: begin
                            state  <= ENUM_WAIT;
                            regime <= RG_ENUM;
                            b      <= 1'b0;
                        end
                        default: ;
                    endcase
                end

                LOAD0: begin
                    y     <= x;
                    state <= LOAD1;
                end

                LOAD1: begin
                    s      <= y[SW-1:0];
                    state  <= IDLE;
                    regime <= RG_IDLE;
                    done   <= 1'b1;
                end

                COUNT: begin
                    if (start) begin
                        s <= s - SW'(1);
                        // s underflow carries into y; y wrapping sets b.
                        if (s == '0) begin
                            y <= y + W'(1);
                            if (&y) b <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        regime <= RG_IDLE;
                        done   <= 1'b1;
                    end
                end

                ENUM_WAIT: begin
                    if (!start) begin
                        s      <= START_V;
                        active <= 1'b1;
                        hold   <= HOLD_M1;
                        state  <= ENUM_RUN;
                    end
                end

                ENUM_RUN: begin
                    if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end else if (can_step) begin
                        s    <= s - STEP_V;
                        hold <= HOLD_M1;
                    end else begin
                        // Last value stays on s after the run ends.
                        state  <= IDLE;
                        regime <= RG_IDLE;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    regime <= RG_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mode_sequencer
//
// Two instances: dut 0 with default parameters, dut 1 with ENUM_START=7,
// ENUM_STEP=3, HOLD=1. A driver issues whole operations (reset, idle, load,
// count, enumerate) and, for each clock it drives, pushes the outputs the
// operation should produce after that edge. A monitor samples just after
// every rising edge and compares against the queue head.
// ---------------------------------------------------------------------------
module tb_mode_sequencer;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        logic [1:0] regime;
        logic       active;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i   [2];
    logic [7:0] x_i     [2];
    logic [1:0] on_i    [2];
    logic       start_i [2];
    logic [7:0] y_o     [2];
    logic [2:0] s_o     [2];
    logic       b_o     [2];
    logic [1:0] regime_o[2];
    logic       active_o[2];
    logic       busy_o  [2];
    logic       done_o  [2];

    always #5 clk = ~clk;

    mode_sequencer u_dut0 (
        .clk(clk), .rst(rst_i[0]), .x(x_i[0]), .on(on_i[0]), .start(start_i[0]),
        .y(y_o[0]), .s(s_o[0]), .b(b_o[0]), .regime(regime_o[0]),
        .active(active_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    mode_sequencer #(.W(8), .SW(3), .ENUM_START(7), .ENUM_STEP(3), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst_i[1]), .x(x_i[1]), .on(on_i[1]), .start(start_i[1]),
        .y(y_o[1]), .s(s_o[1]), .b(b_o[1]), .regime(regime_o[1]),
        .active(active_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Per-instance parameters as seen by the reference model.
    int pes[2] = '{6, 7};
    int pst[2] = '{2, 3};
    int phd[2] = '{2, 1};

    // Reference model: architectural contents of y, s, b.
    logic [7:0] my[2];
    logic [2:0] ms[2];
    logic       mb[2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(int d, logic [1:0] rg, logic act, logic bsy, logic dn);
        exp_t e;
        e.y      = my[d];
        e.s      = ms[d];
        e.b      = mb[d];
        e.regime = rg;
        e.active = act;
        e.busy   = bsy;
        e.done   = dn;
        return e;
    endfunction

    function automatic exp_t grab(int d);
        exp_t g;
        g.y      = y_o[d];
        g.s      = s_o[d];
        g.b      = b_o[d];
        g.regime = regime_o[d];
        g.active = active_o[d];
        g.busy   = busy_o[d];
        g.done   = done_o[d];
        return g;
    endfunction

    // Drive one clock of inputs and queue the outputs expected after the edge.
    task automatic step(int d, logic r, logic [1:0] o, logic st, logic [7:0] xv, exp_t e);
        @(negedge clk);
        rst_i[d]   = r;
        on_i[d]    = o;
        start_i[d] = st;
        x_i[d]     = xv;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic logic [1:0] ron();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic do_reset(int d);
        my[d] = '0; ms[d] = '0; mb[d] = 1'b0;
        step(d, 1'b1, ron(), rbit(), rbyte(), mk(d, 2'd0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic do_idle(int d);
        step(d, 1'b0, 2'd0, rbit(), rbyte(), mk(d, 2'd0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic do_load(int d, logic [7:0] xv);
        mb[d] = 1'b0;
        step(d, 1'b0, 2'd3, rbit(), xv, mk(d, 2'd3, 1'b0, 1'b1, 1'b0));
        my[d] = xv;
        step(d, 1'b0, ron(), rbit(), xv, mk(d, 2'd3, 1'b0, 1'b1, 1'b0));
        ms[d] = xv[2:0];
        step(d, 1'b0, ron(), rbit(), rbyte(), mk(d, 2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    // n counting cycles, then start low to leave. Other mode requests are
    // thrown at the block meanwhile and must be ignored.
    task automatic do_count(int d, int n);
        mb[d] = 1'b0;
        step(d, 1'b0, 2'd2, rbit(), rbyte(), mk(d, 2'd2, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < n; i++) begin
            if (ms[d] == 3'd0) begin
                if (my[d] == 8'hFF) mb[d] = 1'b1;
                my[d] = my[d] + 8'd1;
            end
            ms[d] = ms[d] - 3'd1;
            step(d, 1'b0, ron(), 1'b1, rbyte(), mk(d, 2'd2, 1'b0, 1'b1, 1'b0));
        end
        step(d, 1'b0, ron(), 1'b0, rbyte(), mk(d, 2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    // w cycles waiting with start high, then the enumeration. If abort_at
    // is a valid index, reset replaces the edge that would emit vals[abort_at].
    task automatic do_enum(int d, int w, int abort_at);
        int vals[$];
        mb[d] = 1'b0;
        step(d, 1'b0, 2'd1, (w > 0) ? 1'b1 : 1'b0, rbyte(), mk(d, 2'd1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < w; i++)
            step(d, 1'b0, ron(), 1'b1, rbyte(), mk(d, 2'd1, 1'b0, 1'b1, 1'b0));
        for (int v = pes[d]; v >= 0; v -= pst[d])
            for (int h = 0; h < phd[d]; h++) vals.push_back(v);
        for (int i = 0; i < vals.size(); i++) begin
            if (i == abort_at) begin
                do_reset(d);
                return;
            end
            ms[d] = 3'(vals[i]);
            step(d, 1'b0, ron(), (i == 0) ? 1'b0 : rbit(), rbyte(),
                 mk(d, 2'd1, 1'b1, 1'b1, 1'b0));
        end
        step(d, 1'b0, ron(), rbit(), rbyte(), mk(d, 2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic random_op(int d);
        case ($urandom_range(0, 5))
            0: do_idle(d);
            1: do_load(d, rbyte());
            2: do_count(d, $urandom_range(0, 12));
            3: do_enum(d, $urandom_range(0, 3), -1);
            4: do_enum(d, $urandom_range(0, 2), $urandom_range(0, 9));
            default: do_reset(d);
        endcase
    endtask

    // Monitor: compare every queued expectation right after its edge.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    g = grab(d);
                    checks++;
                    if (g !== e) begin
                        failures++;
                        $display("FAIL dut%0d t=%0t got y=%h s=%0d b=%b rg=%0d act=%b busy=%b done=%b expected y=%h s=%0d b=%b rg=%0d act=%b busy=%b done=%b",
                                 d, $time, g.y, g.s, g.b, g.regime, g.active, g.busy, g.done,
                                 e.y, e.s, e.b, e.regime, e.active, e.busy, e.done);
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; on_i[d] = 2'd0; start_i[d] = 1'b0; x_i[d] = 8'h00;
        end

        // Default instance: directed cases first.
        do_reset(0);
        do_reset(0);
        do_idle(0);
        do_load(0, 8'hA5);            // y=A5, s=5, regime 3,3,0
        do_idle(0);
        do_load(0, 8'hFF);            // s=7, then count down to s=1
        do_count(0, 6);
        do_count(0, 3);               // s=0,7,6; y wraps to 00, b=1
        do_idle(0);
        do_enum(0, 0, -1);            // 6,6,4,4,2,2,0,0
        do_enum(0, 5, -1);            // waits 5 cycles first
        do_load(0, 8'h3C);
        do_enum(0, 0, 3);             // reset while s=4
        // reset with a mode request present on the same edge
        step(0, 1'b1, 2'd3, 1'b1, 8'h77, mk(0, 2'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 40; i++) random_op(0);
        do_idle(0);

        // Swept-parameter instance.
        do_reset(1);
        do_enum(1, 0, -1);            // 7,4,1 one cycle each
        do_load(1, 8'h5B);
        do_enum(1, 2, -1);
        for (int i = 0; i < 20; i++) random_op(1);
        do_idle(1);

        for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) @(posedge clk);
        @(posedge clk);
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, required 0",
                     q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
